// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage plus MEM/WB pipeline register.
// Runs the data-memory req/ack handshake, stalls upstream while an access is
// outstanding, aborts accesses that exceed TIMEOUT cycles and flags misaligned
// or timed-out accesses in a sticky error bit.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 16  // legal range 1..255
) (
    input  logic        clk_i,
    input  logic        start_i,       // asynchronous active-low reset
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] ALUdata_i,
    input  logic [31:0] MemWdata_i,
    input  logic [4:0]  RDaddr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        err_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ALUdata_o,
    output logic [31:0] MemRdata_o,
    output logic [4:0]  RDaddr_o
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] alu_data;
        logic [31:0] mem_rdata;
        logic [4:0]  rd_addr;
    } wb_t;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    wb_t         wb_q, wb_d;
    logic        err_q;

    logic        op;
    logic        misaligned;
    logic        req;
    logic        stall;
    logic        complete;
    logic        err_set;

    assign op         = MemRead_i | MemWrite_i;
    assign misaligned = op & (ALUdata_i[1:0] != 2'b00);

    // Handshake FSM: next state, timeout counter, request/stall and event flags.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        req      = 1'b0;
        stall    = 1'b0;
        complete = 1'b0;
        err_set  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (misaligned) begin
                    err_set = 1'b1;
                end else if (op) begin
                    req = 1'b1;
                    if (mem_ack_i) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = S_WAIT;
                        cnt_d   = 8'd1;
                    end
                end
            end
            S_WAIT: begin
                req = 1'b1;
                if (mem_ack_i) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                    cnt_d    = 8'd0;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    // Abort: retire a bubble this edge and release the pipeline.
                    err_set = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // MEM/WB next value: bubble while stalled or on an error, else pass through.
    always_comb begin
        wb_d = '0;
        if (!stall && !err_set) begin
            wb_d.reg_write  = RegWrite_i;
            wb_d.mem_to_reg = MemtoReg_i;
            wb_d.alu_data   = ALUdata_i;
            wb_d.rd_addr    = RDaddr_i;
            wb_d.mem_rdata  = (complete && !MemWrite_i) ? mem_rdata_i : 32'd0;
        end
    end

    // State, counter, MEM/WB register and sticky error flag.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            wb_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Request and stall are combinational, so reset must gate them directly.
    assign mem_req_o   = req & start_i;
    assign stall_o     = stall & start_i;
    assign mem_we_o    = MemWrite_i;
    assign mem_addr_o  = ALUdata_i;
    assign mem_wdata_o = MemWdata_i;

    assign err_o      = err_q;
    assign RegWrite_o = wb_q.reg_write;
    assign MemtoReg_o = wb_q.mem_to_reg;
    assign ALUdata_o  = wb_q.alu_data;
    assign MemRdata_o = wb_q.mem_rdata;
    assign RDaddr_o   = wb_q.rd_addr;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage with a scoreboard of expected MEM/WB values.
module tb_mem_wb_stage;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] alu_data;
        logic [31:0] mem_rdata;
        logic [4:0]  rd_addr;
    } wb_t;

    logic        clk_i = 1'b0;
    logic        start_i;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
    logic [31:0] ALUdata_i, MemWdata_i;
    logic [4:0]  RDaddr_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o, err_o;
    logic        RegWrite_o, MemtoReg_o;
    logic [31:0] ALUdata_o, MemRdata_o;
    logic [4:0]  RDaddr_o;

    int total = 0;
    int bad   = 0;
    wb_t sb_q[$];

    mem_wb_stage #(.TIMEOUT(4)) dut (
        .clk_i       (clk_i),
        .start_i     (start_i),
        .RegWrite_i  (RegWrite_i),
        .MemtoReg_i  (MemtoReg_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .ALUdata_i   (ALUdata_i),
        .MemWdata_i  (MemWdata_i),
        .RDaddr_i    (RDaddr_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .err_o       (err_o),
        .RegWrite_o  (RegWrite_o),
        .MemtoReg_o  (MemtoReg_o),
        .ALUdata_o   (ALUdata_o),
        .MemRdata_o  (MemRdata_o),
        .RDaddr_o    (RDaddr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic wb_t wb(input logic rw, input logic mtr, input logic [31:0] alu,
                               input logic [31:0] rdata, input logic [4:0] rd);
        wb_t w;
        w.reg_write  = rw;
        w.mem_to_reg = mtr;
        w.alu_data   = alu;
        w.mem_rdata  = rdata;
        w.rd_addr    = rd;
        return w;
    endfunction

    // One pipeline cycle: drive inputs, check combinational outputs, push the
    // expected MEM/WB value, then pop and compare it after the clock edge.
    task automatic step(input string name,
                        input logic rw, input logic mtr, input logic mr, input logic mw,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                        input logic ack, input logic [31:0] rdata,
                        input logic exp_req, input logic exp_stall,
                        input wb_t exp_wb, input logic exp_err);
        wb_t e;
        RegWrite_i  = rw;
        MemtoReg_i  = mtr;
        MemRead_i   = mr;
        MemWrite_i  = mw;
        ALUdata_i   = alu;
        MemWdata_i  = wd;
        RDaddr_i    = rd;
        mem_ack_i   = ack;
        mem_rdata_i = rdata;
        #1;
        check({name, ".req"},   32'(mem_req_o), 32'(exp_req));
        check({name, ".stall"}, 32'(stall_o),   32'(exp_stall));
        if (exp_req) begin
            check({name, ".we"},    32'(mem_we_o),  32'(mw));
            check({name, ".addr"},  mem_addr_o,     alu);
            check({name, ".wdata"}, mem_wdata_o,    wd);
        end
        sb_q.push_back(exp_wb);
        @(posedge clk_i);
        #1;
        if (sb_q.size() == 0) begin
            check({name, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({name, ".RegWrite"}, 32'(RegWrite_o), 32'(e.reg_write));
            check({name, ".MemtoReg"}, 32'(MemtoReg_o), 32'(e.mem_to_reg));
            check({name, ".ALUdata"},  ALUdata_o,       e.alu_data);
            check({name, ".MemRdata"}, MemRdata_o,      e.mem_rdata);
            check({name, ".RDaddr"},   32'(RDaddr_o),   32'(e.rd_addr));
        end
        check({name, ".err"}, 32'(err_o), 32'(exp_err));
    endtask

    initial begin
        wb_t bub;
        bub = '0;
        start_i = 1'b0;
        RegWrite_i = 0; MemtoReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
        ALUdata_i = '0; MemWdata_i = '0; RDaddr_i = '0;
        mem_ack_i = 0; mem_rdata_i = '0;

        // Power-on reset state.
        #12;
        check("rst.req",      32'(mem_req_o),  32'd0);
        check("rst.stall",    32'(stall_o),    32'd0);
        check("rst.err",      32'(err_o),      32'd0);
        check("rst.RegWrite", 32'(RegWrite_o), 32'd0);
        check("rst.ALUdata",  ALUdata_o,       32'd0);
        check("rst.RDaddr",   32'(RDaddr_o),   32'd0);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Non-memory ALU op passes straight through.
        step("alu", 1, 0, 0, 0, 32'h1234, 32'h0, 5'd5, 0, 32'h0,
             0, 0, wb(1, 0, 32'h1234, 32'h0, 5'd5), 0);

        // Zero-wait load.
        step("ld0", 1, 1, 1, 0, 32'h40, 32'h0, 5'd7, 1, 32'hDEADBEEF,
             1, 0, wb(1, 1, 32'h40, 32'hDEADBEEF, 5'd7), 0);

        // Store acknowledged on the fourth cycle; read data must not be captured.
        for (int i = 0; i < 3; i++) begin
            step("st_wait", 0, 0, 0, 1, 32'h80, 32'hA5A5A5A5, 5'd0, 0, 32'h1111,
                 1, 1, bub, 0);
        end
        step("st_ack", 0, 0, 0, 1, 32'h80, 32'hA5A5A5A5, 5'd0, 1, 32'h1111,
             1, 0, wb(0, 0, 32'h80, 32'h0, 5'd0), 0);

        // Load with one wait cycle, read data taken from WAIT.
        step("ld1_wait", 1, 1, 1, 0, 32'h100, 32'h0, 5'd9, 0, 32'h0,
             1, 1, bub, 0);
        step("ld1_ack", 1, 1, 1, 0, 32'h100, 32'h0, 5'd9, 1, 32'hCAFEF00D,
             1, 0, wb(1, 1, 32'h100, 32'hCAFEF00D, 5'd9), 0);

        // Read and write both set: the write wins.
        step("rw_both", 0, 0, 1, 1, 32'h104, 32'h5555AAAA, 5'd3, 1, 32'h7777,
             1, 0, wb(0, 0, 32'h104, 32'h0, 5'd3), 0);

        // Misaligned load: no request, ack ignored, bubble, sticky error.
        step("misal", 1, 1, 1, 0, 32'h42, 32'h0, 5'd4, 1, 32'h9999,
             0, 0, bub, 1);
        step("after_misal", 1, 0, 0, 0, 32'h8, 32'h0, 5'd6, 0, 32'h0,
             0, 0, wb(1, 0, 32'h8, 32'h0, 5'd6), 1);

        // Reset in the middle of a WAIT.
        step("rwait0", 1, 1, 1, 0, 32'h200, 32'h0, 5'd2, 0, 32'h0, 1, 1, bub, 1);
        step("rwait1", 1, 1, 1, 0, 32'h200, 32'h0, 5'd2, 0, 32'h0, 1, 1, bub, 1);
        check("midwait.req", 32'(mem_req_o), 32'd1);
        start_i = 1'b0;
        #1;
        check("midrst.req",      32'(mem_req_o),  32'd0);
        check("midrst.stall",    32'(stall_o),    32'd0);
        check("midrst.err",      32'(err_o),      32'd0);
        check("midrst.RegWrite", 32'(RegWrite_o), 32'd0);
        check("midrst.MemRdata", MemRdata_o,      32'd0);
        MemRead_i = 0; RegWrite_i = 0; MemtoReg_i = 0; ALUdata_i = '0; RDaddr_i = '0;
        #1;
        start_i = 1'b1;
        step("post_rst", 1, 0, 0, 0, 32'hABC0, 32'h0, 5'd11, 0, 32'h0,
             0, 0, wb(1, 0, 32'hABC0, 32'h0, 5'd11), 0);

        // Timeout with TIMEOUT = 4: four stall cycles, then abort as a bubble.
        for (int i = 0; i < 4; i++) begin
            step("to_wait", 1, 1, 1, 0, 32'h300, 32'h0, 5'd12, 0, 32'h0,
                 1, 1, bub, 0);
        end
        step("to_abort", 1, 1, 1, 0, 32'h300, 32'h0, 5'd12, 0, 32'h0,
             1, 0, bub, 1);
        step("after_to", 1, 0, 0, 0, 32'h44, 32'h0, 5'd13, 0, 32'h0,
             0, 0, wb(1, 0, 32'h44, 32'h0, 5'd13), 1);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
